spi_slave_regs: RTL and testbench

SPI register responder matching the frame format driven by the housekeeping SPI master: 16-bit header (R/W flag plus address) followed by 8 data bits, MSB first. It oversamples the SPI pins in the `clk_i` domain and holds a small byte-wide register file. The file is written by SPI write frames and returned on SPI read frames. It sits on the far end of the housekeeping SPI link: as an ADC register-map model in benches, and as a configuration target in daisy-chained boards.

---
 rtl/spi_slave_regs.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_regs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI register responder: 16-bit header (R/W + 13-bit address) then 8 data bits, MSB first, oversampled in clk_i.
// Optional 3-wire SDIO tristate behaviour is selected with `define SPI_SLV_3WIRE_EN.
module spi_slave_regs #(
  parameter int NREG = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_cs_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic [NREG*8-1:0] regs_o,
  output logic              wr_strb_o,
  output logic [12:0]       wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              rd_strb_o,
  output logic              frm_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cs_sync, sck_sync;
  logic [1:0]  mosi_sync;
  logic        cs_fall_q, cs_rise_q, sck_rise_q, sck_fall_q, mosi_q;
  logic [4:0]  cnt_q;
  logic        rw_q;
  logic [12:0] addr_sr;
  logic [6:0]  data_sr;
  logic [7:0]  tx_sr;
  logic [7:0]  regs_q [NREG];
  logic [7:0]  rd_byte;
  logic [12:0] hdr_addr_nxt;
  logic [7:0]  data_nxt;
  logic        start, hdr_done, frame_done, abort, addr_ok, wr_ok;

  // Index 0/1 form the synchronizer, index 2 is the previous value for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_sync    <= 3'b111;
      sck_sync   <= 3'b111;
      mosi_sync  <= 2'b00;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[1:0], spi_cs_i};
      sck_sync   <= {sck_sync[1:0], spi_clk_i};
      mosi_sync  <= {mosi_sync[0], spi_mosi_i};
      cs_fall_q  <= cs_sync[2] & ~cs_sync[1];
      cs_rise_q  <= ~cs_sync[2] & cs_sync[1];
      sck_rise_q <= ~sck_sync[2] & sck_sync[1];
      sck_fall_q <= sck_sync[2] & ~sck_sync[1];
      mosi_q     <= mosi_sync[1];
    end
  end

  assign hdr_addr_nxt = {addr_sr[11:0], mosi_q};
  assign data_nxt     = {data_sr, mosi_q};
  assign addr_ok      = {19'd0, addr_sr} < 32'(NREG);
  assign wr_ok        = frame_done & ~rw_q & addr_ok;
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    rd_byte = 8'h00;
    for (int n = 0; n < NREG; n++) begin
      if (hdr_addr_nxt == 13'(n)) rd_byte = regs_q[n];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int n = 0; n < NREG; n++) regs_o[n*8 +: 8] = regs_q[n];
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    hdr_done   = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: if (cs_fall_q) begin
        start   = 1'b1;
        state_d = HDR;
      end
      HDR: begin
        if (cs_rise_q) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise_q && cnt_q == 5'd15) begin
          hdr_done = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        // The final data edge wins over a coincident CS release.
        if (sck_rise_q && cnt_q == 5'd23) begin
          frame_done = 1'b1;
          state_d    = cs_rise_q ? IDLE : DONE;
        end else if (cs_rise_q) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: if (cs_rise_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_sr    <= '0;
      data_sr    <= '0;
      tx_sr      <= '0;
      spi_miso_o <= 1'b0;
      wr_strb_o  <= 1'b0;
      rd_strb_o  <= 1'b0;
      frm_err_o  <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      for (int n = 0; n < NREG; n++) regs_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      wr_strb_o <= wr_ok;
      rd_strb_o <= frame_done & rw_q;
      frm_err_o <= abort;
      if (start || abort) begin
        cnt_q   <= '0;
        rw_q    <= 1'b0;
        addr_sr <= '0;
        data_sr <= '0;
        tx_sr   <= '0;
      end else if (sck_rise_q && (state_q == HDR || state_q == DATA)) begin
        cnt_q <= cnt_q + 5'd1;
        if (state_q == HDR) begin
          addr_sr <= hdr_addr_nxt;
          if (cnt_q == 5'd0) rw_q  <= mosi_q;
          if (hdr_done)      tx_sr <= rd_byte;
        end else begin
          data_sr <= data_nxt[6:0];
        end
      end else if (sck_fall_q && state_q == DATA && rw_q) begin
        spi_miso_o <= tx_sr[7];
        tx_sr      <= {tx_sr[6:0], 1'b0};
      end
      if (wr_ok) begin
        wr_addr_o <= addr_sr;
        wr_data_o <= data_nxt;
        for (int n = 0; n < NREG; n++) begin
          if (addr_sr == 13'(n)) regs_q[n] <= data_nxt;
        end
      end
    end
  end

`ifdef SPI_SLV_3WIRE_EN
  logic oe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         oe_q <= 1'b0;
    else if (state_d != DATA)                          oe_q <= 1'b0;
    else if (sck_fall_q && state_q == DATA && rw_q)    oe_q <= 1'b1;
  end

  assign spi_miso_t = ~oe_q;
`else
  assign spi_miso_t = cs_sync[1];
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: frame-level model with cycle-stamped expected events, checked every cycle.
module tb_spi_slave_regs;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         spi_cs_i, spi_clk_i, spi_mosi_i;
  logic         spi_miso_o, spi_miso_t;
  logic [127:0] regs_o;
  logic         wr_strb_o, rd_strb_o, frm_err_o, busy_o;
  logic [12:0]  wr_addr_o;
  logic [7:0]   wr_data_o;

  spi_slave_regs #(.NREG(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .spi_cs_i(spi_cs_i), .spi_clk_i(spi_clk_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
    .regs_o(regs_o), .wr_strb_o(wr_strb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_strb_o(rd_strb_o), .frm_err_o(frm_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  // Model state: register image, last write, and events stamped with the cycle they must appear.
  logic [127:0] m_regs = '0;
  logic [12:0]  m_wa = '0;
  logic [7:0]   m_wd = '0;
  int           ev_wr  [int];
  bit           ev_rd  [int];
  bit           ev_err [int];
  bit           tlow   [int];
  bit           cs_log [int];
  int           wr_cnt = 0, rd_cnt = 0, err_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit cs_at(input int c);
    return cs_log.exists(c) ? cs_log[c] : 1'b1;
  endfunction

  always @(negedge clk_i) begin
    bit e_wr, e_rd, e_err, e_t;
    cs_log[cyc] = rst_i ? 1'b1 : spi_cs_i;
    if (rst_i) begin
      for (int k = 1; k <= 4; k++) cs_log[cyc-k] = 1'b1;
      m_regs = '0; m_wa = '0; m_wd = '0;
      ev_wr.delete(); ev_rd.delete(); ev_err.delete(); tlow.delete();
      chk("miso_rst", {127'd0, spi_miso_o}, 128'd0);
    end
    e_wr  = ev_wr.exists(cyc);
    e_rd  = ev_rd.exists(cyc);
    e_err = ev_err.exists(cyc);
    if (e_wr) begin
      m_wa = 13'(ev_wr[cyc] >> 8);
      m_wd = 8'(ev_wr[cyc]);
      m_regs[m_wa*8 +: 8] = m_wd;
    end
`ifdef SPI_SLV_3WIRE_EN
    e_t = !tlow.exists(cyc);
`else
    e_t = cs_at(cyc - 2);
`endif
    chk("wr_strb", {127'd0, wr_strb_o}, {127'd0, e_wr});
    chk("rd_strb", {127'd0, rd_strb_o}, {127'd0, e_rd});
    chk("frm_err", {127'd0, frm_err_o}, {127'd0, e_err});
    chk("busy",    {127'd0, busy_o},    {127'd0, !cs_at(cyc - 4)});
    chk("miso_t",  {127'd0, spi_miso_t}, {127'd0, e_t});
    chk("regs",    regs_o, m_regs);
    chk("wr_addr", {115'd0, wr_addr_o}, {115'd0, m_wa});
    chk("wr_data", {120'd0, wr_data_o}, {120'd0, m_wd});
    if (wr_strb_o) wr_cnt++;
    if (rd_strb_o) rd_cnt++;
    if (frm_err_o) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One SPI frame, 8 clk_i per SPI clock. rst_at >= 0 pulses reset before that SPI clock;
  // conflict releases CS together with the 24th rising edge.
  task automatic frame(input logic [15:0] hdr, input logic [7:0] dat, input int nclk,
                       input int rst_at, input bit conflict, output logic [7:0] rx);
    bit rw;
    logic [12:0] addr;
    rw   = hdr[15];
    addr = hdr[12:0];
    rx   = 8'h00;
    spi_cs_i = 1'b0;
    tick(4);
    for (int i = 0; i < nclk; i++) begin
      if (i == rst_at) begin
        rst_i = 1'b1; spi_cs_i = 1'b1; spi_clk_i = 1'b1; spi_mosi_i = 1'b0;
        tick(3);
        rst_i = 1'b0;
        tick(8);
        return;
      end
      spi_clk_i  = 1'b0;
      spi_mosi_i = (i < 16) ? hdr[15-i] : (i < 24) ? dat[23-i] : 1'b1;
      if (rw && i >= 16 && i < 24)
        for (int k = 4; k < ((i == 23) ? 8 : 12); k++) tlow[cyc+k] = 1'b1;
      tick(4);
      if (i >= 16 && i < 24) rx = {rx[6:0], spi_miso_o};
      spi_clk_i = 1'b1;
      if (i == 23) begin
        if (conflict) spi_cs_i = 1'b1;
        if (rw) ev_rd[cyc+4] = 1'b1;
        else if (addr < 13'd16) ev_wr[cyc+4] = {addr, 8'h00} | int'(dat);
      end
      tick(4);
    end
    if (!spi_cs_i) begin
      spi_cs_i = 1'b1;
      if (nclk < 24) ev_err[cyc+4] = 1'b1;
    end
    tick(8);
  endtask

  initial begin
    logic [7:0]   rx;
    logic [127:0] snap;
    int w0, r0, e0;
    rst_i = 1'b1; spi_cs_i = 1'b1; spi_clk_i = 1'b1; spi_mosi_i = 1'b0;
    tick(3);
    chk("reset_regs",  regs_o, 128'd0);
    chk("reset_busy",  {127'd0, busy_o}, 128'd0);
    chk("reset_mt",    {127'd0, spi_miso_t}, 128'd1);
    rst_i = 1'b0;
    tick(3);

    // Write 0x05 <= 0xA5
    w0 = wr_cnt;
    frame(16'h0005, 8'hA5, 24, -1, 1'b0, rx);
    chk("w5_reg",   {120'd0, regs_o[47:40]}, 128'hA5);
    chk("w5_addr",  {115'd0, wr_addr_o}, 128'd5);
    chk("w5_data",  {120'd0, wr_data_o}, 128'hA5);
    chk("w5_pulses", 128'(wr_cnt - w0), 128'd1);

    // Read back 0x05
    r0 = rd_cnt; snap = regs_o;
    frame(16'h8005, 8'h00, 24, -1, 1'b0, rx);
    chk("r5_data",   {120'd0, rx}, 128'hA5);
    chk("r5_pulses", 128'(rd_cnt - r0), 128'd1);
    chk("r5_regs",   regs_o, snap);

    // Abort after 10 header bits
    w0 = wr_cnt; e0 = err_cnt; snap = regs_o;
    frame(16'h0006, 8'hFF, 10, -1, 1'b0, rx);
    chk("ab_err",  128'(err_cnt - e0), 128'd1);
    chk("ab_wr",   128'(wr_cnt - w0), 128'd0);
    chk("ab_regs", regs_o, snap);
    chk("ab_busy", {127'd0, busy_o}, 128'd0);

    // Out-of-range write then read
    w0 = wr_cnt; r0 = rd_cnt; snap = regs_o;
    frame(16'h0010, 8'h3C, 24, -1, 1'b0, rx);
    chk("oor_wr",   128'(wr_cnt - w0), 128'd0);
    chk("oor_regs", regs_o, snap);
    frame(16'h8010, 8'h00, 24, -1, 1'b0, rx);
    chk("oor_rd",   {120'd0, rx}, 128'h00);
    chk("oor_rdp",  128'(rd_cnt - r0), 128'd1);

    // Header bits 14:13 ignored, 30 SPI clocks: only bits 17-24 are written
    w0 = wr_cnt;
    frame(16'h6007, 8'hC3, 30, -1, 1'b0, rx);
    chk("xc_pulses", 128'(wr_cnt - w0), 128'd1);
    chk("xc_reg",    {120'd0, regs_o[63:56]}, 128'hC3);
    frame(16'h8007, 8'h00, 24, -1, 1'b0, rx);
    chk("xc_rd",     {120'd0, rx}, 128'hC3);

    // Reset in the middle of the data phase, then a clean frame
    e0 = err_cnt;
    frame(16'h0002, 8'h77, 24, 20, 1'b0, rx);
    chk("rs_regs", regs_o, 128'd0);
    chk("rs_addr", {115'd0, wr_addr_o}, 128'd0);
    chk("rs_err",  128'(err_cnt - e0), 128'd0);
    frame(16'h0002, 8'h77, 24, -1, 1'b0, rx);
    chk("rs_next", {120'd0, regs_o[23:16]}, 128'h77);

    // CS release coincident with the final rising edge completes the write
    w0 = wr_cnt; e0 = err_cnt;
    frame(16'h0003, 8'h5A, 24, -1, 1'b1, rx);
    chk("cf_wr",  128'(wr_cnt - w0), 128'd1);
    chk("cf_err", 128'(err_cnt - e0), 128'd0);
    chk("cf_reg", {120'd0, regs_o[31:24]}, 128'h5A);
    frame(16'h800F, 8'h00, 24, -1, 1'b0, rx);
    chk("r15_zero", {120'd0, rx}, 128'h00);
    frame(16'h8003, 8'h00, 24, -1, 1'b0, rx);
    chk("cf_rd",  {120'd0, rx}, 128'h5A);

    tick(4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
